mux_key_table: RTL and testbench

- Programmable key/data table that produces the packed `lut` bus consumed by the MuxKey / MuxKeyWithDefault selectors.
- Removes the need for the selector to take a hard-wired constant LUT: firmware, a decoder or a CSR block loads, updates, deletes and clears entries at run time through a valid/ready command port.
- `lut` output layout is bit-exact with the selector's input:
  - entry n occupies bits [PAIR_LEN*(n+1)-1 : PAIR_LEN*n];
  - within an entry, the key is in the upper KEY_LEN bits and the data in the lower DATA_LEN bits.

---
 rtl/mux_key_table.sv | 224 ++++++++++++++++++++++
 tb/tb_mux_key_table.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key_table.sv
// Run-time loadable key/data table that drives the packed lut bus of a MuxKey selector.
// Latency: upsert/delete respond 1 cycle after accept; clear takes NR_KEY+1 cycles; compacting delete takes NR_KEY-s cycles.
// Backpressure: cmd_ready drops while a clear or compaction walks the table; commands are held by the source, never dropped.
// Optional feature: define MUX_KEY_TABLE_COMPACT_EN to keep live entries packed into the low slots after a delete.
module mux_key_table #(
    parameter int NR_KEY = 4,
    parameter int KEY_LEN = 4,
    parameter int DATA_LEN = 8,
    parameter logic [KEY_LEN-1:0] FILL_KEY = {KEY_LEN{1'b1}}
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [1:0]                              cmd_op,
    input  logic [KEY_LEN-1:0]                      cmd_key,
    input  logic [DATA_LEN-1:0]                     cmd_data,
    output logic                                    resp_valid,
    output logic [1:0]                              resp_status,
    output logic [$clog2(NR_KEY)-1:0]               resp_slot,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut,
    output logic [NR_KEY-1:0]                       valid_mask,
    output logic [$clog2(NR_KEY+1)-1:0]             count,
    output logic                                    full
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
    localparam int SLOT_W   = $clog2(NR_KEY);
    localparam int CNT_W    = $clog2(NR_KEY + 1);

    localparam logic [1:0] OP_UPSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    localparam logic [1:0] ST_INS = 2'b00;
    localparam logic [1:0] ST_UPD = 2'b01;
    localparam logic [1:0] ST_REM = 2'b10;
    localparam logic [1:0] ST_ERR = 2'b11;

`ifdef MUX_KEY_TABLE_COMPACT_EN
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COMPACT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CLEAR} state_t;
`endif

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      idx_q, idx_d;
    logic [KEY_LEN-1:0]     key_q  [NR_KEY];
    logic [KEY_LEN-1:0]     key_d  [NR_KEY];
    logic [DATA_LEN-1:0]    data_q [NR_KEY];
    logic [DATA_LEN-1:0]    data_d [NR_KEY];
    logic [NR_KEY-1:0]      vld_q, vld_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [1:0]             resp_status_q, resp_status_d;
    logic [SLOT_W-1:0]      resp_slot_q, resp_slot_d;

    logic                   hit, free;
    logic [SLOT_W-1:0]      hit_idx, free_idx;
    logic                   accept;
`ifdef MUX_KEY_TABLE_COMPACT_EN
    logic [SLOT_W-1:0]      idx_nxt;
`endif

    assign cmd_ready = rst_n && (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Locate the live slot holding cmd_key and the lowest-index free slot.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (vld_q[i] && (key_q[i] == cmd_key)) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
            if (!vld_q[i]) begin
                free     = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    // Next-state and table update for command execution, clear walk and compaction.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        key_d         = key_q;
        data_d        = data_q;
        vld_d         = vld_q;
        resp_valid_d  = 1'b0;
        resp_status_d = resp_status_q;
        resp_slot_d   = resp_slot_q;
`ifdef MUX_KEY_TABLE_COMPACT_EN
        idx_nxt       = idx_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_UPSERT: begin
                            resp_valid_d  = 1'b1;
                            resp_status_d = ST_ERR;
                            resp_slot_d   = '0;
                            if (cmd_key == FILL_KEY) begin
                                resp_status_d = ST_ERR;
                            end else if (hit) begin
                                data_d[hit_idx] = cmd_data;
                                resp_status_d   = ST_UPD;
                                resp_slot_d     = hit_idx;
                            end else if (free) begin
                                key_d[free_idx]  = cmd_key;
                                data_d[free_idx] = cmd_data;
                                vld_d[free_idx]  = 1'b1;
                                resp_status_d    = ST_INS;
                                resp_slot_d      = free_idx;
                            end
                        end
                        OP_DELETE: begin
                            resp_valid_d  = 1'b1;
                            resp_status_d = ST_ERR;
                            resp_slot_d   = '0;
                            if (hit) begin
                                key_d[hit_idx]  = FILL_KEY;
                                data_d[hit_idx] = '0;
                                vld_d[hit_idx]  = 1'b0;
                                resp_status_d   = ST_REM;
                                resp_slot_d     = hit_idx;
`ifdef MUX_KEY_TABLE_COMPACT_EN
                                // The top slot leaves no hole; anything lower shifts down first.
                                if (hit_idx != SLOT_W'(NR_KEY - 1)) begin
                                    resp_valid_d = 1'b0;
                                    state_d      = S_COMPACT;
                                    idx_d        = hit_idx;
                                end
`endif
                            end
                        end
                        OP_CLEAR: begin
                            state_d = S_CLEAR;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLEAR: begin
                key_d[idx_q]  = FILL_KEY;
                data_d[idx_q] = '0;
                vld_d[idx_q]  = 1'b0;
                if (idx_q == SLOT_W'(NR_KEY - 1)) begin
                    state_d       = S_IDLE;
                    idx_d         = '0;
                    resp_valid_d  = 1'b1;
                    resp_status_d = ST_REM;
                    resp_slot_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef MUX_KEY_TABLE_COMPACT_EN
            S_COMPACT: begin
                // Pull the next entry down and vacate its old slot so the live count never changes mid-walk.
                key_d[idx_q]    = key_q[idx_nxt];
                data_d[idx_q]   = data_q[idx_nxt];
                vld_d[idx_q]    = vld_q[idx_nxt];
                key_d[idx_nxt]  = FILL_KEY;
                data_d[idx_nxt] = '0;
                vld_d[idx_nxt]  = 1'b0;
                if (idx_q == SLOT_W'(NR_KEY - 2)) begin
                    state_d      = S_IDLE;
                    idx_d        = '0;
                    resp_valid_d = 1'b1;
                end else begin
                    idx_d = idx_nxt;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and table registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            vld_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= '0;
            resp_slot_q   <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= FILL_KEY;
                data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            vld_q         <= vld_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_slot_q   <= resp_slot_d;
            key_q         <= key_d;
            data_q        <= data_d;
        end
    end

    // Pack slots into selector format and derive occupancy.
    always_comb begin
        lut   = '0;
        count = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            lut[PAIR_LEN*i +: PAIR_LEN] = {key_q[i], data_q[i]};
            count = count + CNT_W'(vld_q[i]);
        end
    end

    assign valid_mask  = vld_q;
    assign full        = (count == CNT_W'(NR_KEY));
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign resp_slot   = resp_slot_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Randomised scoreboard bench for mux_key_table against a slot-array reference model.
// Expected responses are queued at command acceptance and checked by an independent monitor.
// Directed cases cover reset, update, full/error paths, delete holes or compaction, clear backpressure and reset mid-clear.
module tb_mux_key_table;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_key;
    logic [7:0]  cmd_data;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [1:0]  resp_slot;
    logic [47:0] lut;
    logic [3:0]  valid_mask;
    logic [2:0]  count;
    logic        full;

    mux_key_table dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_key     (cmd_key),
        .cmd_data    (cmd_data),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .resp_slot   (resp_slot),
        .lut         (lut),
        .valid_mask  (valid_mask),
        .count       (count),
        .full        (full)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic [1:0]  slot;
        logic [47:0] lut;
        logic [3:0]  mask;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Reference table: a plain array of (key, data, live) entries.
    logic [3:0]  mk [4];
    logic [7:0]  md [4];
    logic [3:0]  mv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    function automatic logic [47:0] model_lut();
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            v[12*i +: 12] = mv[i] ? {mk[i], md[i]} : 12'hF00;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mk[i] = 4'hF;
            md[i] = 8'h00;
        end
        mv = 4'b0000;
    endtask

    // Apply an accepted command to the model and queue the response it must produce.
    task automatic model_apply(input logic [1:0] op, input logic [3:0] k, input logic [7:0] d, input int c);
        exp_t e;
        int   hit;
        int   fr;
        if (op == 2'b11) return;
        hit = -1;
        fr  = -1;
        for (int i = 0; i < 4; i++) begin
            if (hit < 0 && mv[i] && mk[i] == k) hit = i;
            if (fr < 0 && !mv[i]) fr = i;
        end
        e.cyc  = c + 1;
        e.st   = 2'b11;
        e.slot = 2'd0;
        if (op == 2'b00) begin
            if (k == 4'hF) begin
                e.st = 2'b11;
            end else if (hit >= 0) begin
                md[hit] = d;
                e.st    = 2'b01;
                e.slot  = 2'(hit);
            end else if (fr >= 0) begin
                mk[fr] = k;
                md[fr] = d;
                mv[fr] = 1'b1;
                e.st   = 2'b00;
                e.slot = 2'(fr);
            end
        end else if (op == 2'b01) begin
            if (hit >= 0) begin
                e.st   = 2'b10;
                e.slot = 2'(hit);
`ifdef MUX_KEY_TABLE_COMPACT_EN
                // Remove from the ordered list; everything above moves down one place.
                for (int i = hit; i < 3; i++) begin
                    mk[i] = mk[i+1];
                    md[i] = md[i+1];
                    mv[i] = mv[i+1];
                end
                mk[3] = 4'hF;
                md[3] = 8'h00;
                mv[3] = 1'b0;
                e.cyc = c + (4 - hit);
`else
                mk[hit] = 4'hF;
                md[hit] = 8'h00;
                mv[hit] = 1'b0;
`endif
            end
        end else begin
            model_clear();
            e.st  = 2'b10;
            e.cyc = c + 5;
        end
        e.lut  = model_lut();
        e.mask = mv;
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] k, input logic [7:0] d, output int acc);
        int waited;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = k;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL accept_timeout: cmd_ready stayed %b for op %0d", cmd_ready, op);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        model_apply(op, k, d, cyc);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every response strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL resp_unexpected: resp_valid=1 status=%0d with nothing pending", resp_status);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_cycle",  64'(cyc),         64'(mon_e.cyc));
                chk("resp_status", 64'(resp_status), 64'(mon_e.st));
                chk("resp_slot",   64'(resp_slot),   64'(mon_e.slot));
                chk("lut",         64'(lut),         64'(mon_e.lut));
                chk("valid_mask",  64'(valid_mask),  64'(mon_e.mask));
                chk("count",       64'(count),       64'($countones(mon_e.mask)));
                chk("full",        64'(full),        64'(mon_e.mask == 4'b1111));
            end
        end
    end

    initial begin
        int         acc;
        int         acc_b;
        int         r;
        logic [1:0] op;
        logic [3:0] k;
        logic [7:0] d;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_key   = 4'h0;
        cmd_data  = 8'h00;
        model_clear();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready",  64'(cmd_ready),  64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mask",       64'(valid_mask), 64'd0);
        chk("rst_count",      64'(count),      64'd0);
        chk("rst_lut",        64'(lut),        64'hF00F00F00F00);
        chk("rst_status",     64'(resp_status), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Insert then update the same key.
        send(2'b00, 4'h3, 8'hA5, acc);
        wait_drain();
        chk("ins_lut0", 64'(lut[11:0]), 64'h3A5);
        send(2'b00, 4'h3, 8'h5A, acc);
        wait_drain();
        chk("upd_lut0", 64'(lut[11:0]), 64'h35A);
        chk("upd_count", 64'(count), 64'd1);

        // Fill the table, then overflow.
        send(2'b00, 4'h1, 8'h11, acc);
        send(2'b00, 4'h2, 8'h22, acc);
        send(2'b00, 4'h4, 8'h44, acc);
        send(2'b00, 4'h9, 8'h99, acc);
        wait_drain();
        chk("full_flag", 64'(full), 64'd1);

        // Reserved key on an empty table.
        send(2'b10, 4'h0, 8'h00, acc);
        send(2'b00, 4'hF, 8'h12, acc);
        wait_drain();

        // Delete from the middle of three entries.
        send(2'b00, 4'h1, 8'h01, acc);
        send(2'b00, 4'h2, 8'h02, acc);
        send(2'b00, 4'h3, 8'h03, acc);
        send(2'b01, 4'h2, 8'h00, acc);
        wait_drain();
`ifdef MUX_KEY_TABLE_COMPACT_EN
        chk("del_mask", 64'(valid_mask), 64'b0011);
        chk("del_slot1_key", 64'(lut[23:20]), 64'h3);
`else
        chk("del_slot1", 64'(lut[23:12]), 64'hF00);
        chk("del_mask", 64'(valid_mask), 64'b0101);
`endif
        send(2'b00, 4'h7, 8'h77, acc);
        wait_drain();
`ifndef MUX_KEY_TABLE_COMPACT_EN
        chk("refill_slot1_key", 64'(lut[23:20]), 64'h7);
`endif

        // Absent key delete, and a nop.
        send(2'b01, 4'h5, 8'h00, acc);
        send(2'b11, 4'h6, 8'h66, acc);
        wait_drain();

        // Clear with an upsert held right behind it.
        send(2'b10, 4'h0, 8'h00, acc);
        send(2'b00, 4'h6, 8'h66, acc_b);
        chk("b2b_accept_cycle", 64'(acc_b), 64'(acc + 5));
        wait_drain();

        // Random command mix.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 19);
            k = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) k = 4'hF;
            d = 8'($urandom);
            if (r < 10)      op = 2'b00;
            else if (r < 16) op = 2'b01;
            else if (r < 18) op = 2'b11;
            else             op = 2'b10;
            send(op, k, d, acc);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_drain();

        // Reset in the middle of a clear walk.
        send(2'b10, 4'h0, 8'h00, acc);
        send(2'b00, 4'h1, 8'h10, acc);
        send(2'b00, 4'h2, 8'h20, acc);
        send(2'b00, 4'h3, 8'h30, acc);
        wait_drain();
        send(2'b10, 4'h0, 8'h00, acc);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midclr_resp_valid", 64'(resp_valid), 64'd0);
        chk("midclr_mask",       64'(valid_mask), 64'd0);
        chk("midclr_lut",        64'(lut),        64'hF00F00F00F00);
        chk("midclr_ready",      64'(cmd_ready),  64'd0);
        sb.delete();
        model_clear();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midclr_ready_after", 64'(cmd_ready), 64'd1);
        send(2'b00, 4'h8, 8'h88, acc);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
